// File: rtl/updown_button_ctrl.sv
// Two-button front end for the up/down counter: synchronize, debounce and
// turn button presses/holds into a direction bit, a one-cycle step strobe and a conflict flag.
module updown_button_ctrl #(
   parameter int unsigned DB_CYCLES  = 16,
   parameter int unsigned REP_DELAY  = 64,
   parameter int unsigned REP_PERIOD = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic btn_up,
   input  logic btn_dn,
   output logic m,
   output logic step,
   output logic lock
);

   localparam int unsigned DB_W         = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);

   localparam int unsigned REP_MAX      = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int unsigned REP_W        = (REP_MAX < 2) ? 1 : $clog2(REP_MAX);
   localparam int unsigned REP_DELAY_M1 = (REP_DELAY == 0) ? 0 : REP_DELAY - 1;
   localparam int unsigned REP_PER_M1   = (REP_PERIOD == 0) ? 0 : REP_PERIOD - 1;
   localparam bit          REP_EN       = (REP_DELAY != 0);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_UP_HELD = 2'd1;
   localparam logic [1:0] ST_DN_HELD = 2'd2;
   localparam logic [1:0] ST_LOCK    = 2'd3;

   // Bit 0 carries the up button, bit 1 the down button.
   logic [1:0]      sync1_q, sync1_d;
   logic [1:0]      sync2_q, sync2_d;
   logic [1:0]      deb_q, deb_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];

   logic [1:0]       state_q, state_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_first_q, rep_first_d;
   logic             m_q, m_d;
   logic             step_q, step_d;
   logic             lock_q, lock_d;

   logic             up_lvl_c;
   logic             dn_lvl_c;
   logic             held_dn_c;
   logic             own_lvl_c;
   logic             other_lvl_c;
   logic [REP_W-1:0] rep_target_c;

   // Two-flop synchronizer per raw button.
   always_comb begin
      sync1_d = {btn_dn, btn_up};
      sync2_d = sync1_q;
   end

   // Debouncer: a level change is accepted after DB_CYCLES consecutive differing samples.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   assign up_lvl_c     = deb_q[0];
   assign dn_lvl_c     = deb_q[1];
   assign held_dn_c    = (state_q == ST_DN_HELD);
   assign own_lvl_c    = held_dn_c ? dn_lvl_c : up_lvl_c;
   assign other_lvl_c  = held_dn_c ? up_lvl_c : dn_lvl_c;
   assign rep_target_c = rep_first_q ? REP_W'(REP_DELAY_M1) : REP_W'(REP_PER_M1);

   // Press/hold FSM with auto-repeat; the hold counter restarts at every step it issues.
   always_comb begin
      state_d     = state_q;
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      m_d         = m_q;
      step_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (up_lvl_c && dn_lvl_c) begin
               state_d = ST_LOCK;
            end else if (up_lvl_c) begin
               state_d     = ST_UP_HELD;
               m_d         = 1'b0;
               step_d      = 1'b1;
               rep_cnt_d   = '0;
               rep_first_d = 1'b1;
            end else if (dn_lvl_c) begin
               state_d     = ST_DN_HELD;
               m_d         = 1'b1;
               step_d      = 1'b1;
               rep_cnt_d   = '0;
               rep_first_d = 1'b1;
            end
         end
         ST_UP_HELD, ST_DN_HELD: begin
            if (other_lvl_c) begin
               state_d = ST_LOCK;
            end else if (!own_lvl_c) begin
               state_d = ST_IDLE;
            end else if (REP_EN) begin
               if (rep_cnt_q == rep_target_c) begin
                  m_d         = held_dn_c;
                  step_d      = 1'b1;
                  rep_cnt_d   = '0;
                  rep_first_d = 1'b0;
               end else begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
               end
            end
         end
         ST_LOCK: begin
            if (!up_lvl_c && !dn_lvl_c) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      lock_d = (state_d == ST_LOCK);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         deb_q       <= '0;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
         state_q     <= ST_IDLE;
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b0;
         m_q         <= 1'b0;
         step_q      <= 1'b0;
         lock_q      <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_q       <= deb_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
         state_q     <= state_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
         m_q         <= m_d;
         step_q      <= step_d;
         lock_q      <= lock_d;
      end
   end

   assign m    = m_q;
   assign step = step_q;
   assign lock = lock_q;

endmodule

// File: doc/updown_button_ctrl.md
# updown_button_ctrl

Front-end controller that feeds the synchronous up/down counter. It turns two raw, bouncing push-buttons (up, down) into a clean direction signal `m` and a one-cycle `step` strobe. The strobe is used to qualify counting. Each button passes through a synchronizer, a debouncer and a press/hold state machine with optional auto-repeat. Direction encoding matches the counter: `m`=0 counts up, `m`=1 counts down.

## Interface
- DB_CYCLES, 16: consecutive stable synchronized samples required to accept a level change (≥1).
- REP_DELAY, 64: cycles from the initial press `step` to the first auto-repeat `step`; 0 disables auto-repeat.
- REP_PERIOD, 16: cycles between later auto-repeat `step` pulses (≥1).
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- btn_up  in  1  raw up button, asynchronous, active-high.
- btn_dn  in  1  raw down button, asynchronous, active-high.
- m  out  1  direction (0 up, 1 down), registered.
- step  out  1  one-cycle count strobe, registered.
- lock  out  1  high while both buttons are held (conflict), registered.

## Operation
- Reset (`clr`=0, async): all synchronizer flops, debounced levels, counters and the FSM clear immediately. `m`=0, `step`=0, `lock`=0, state IDLE.
- Synchronizer: 2 flops per button, reset to 0.
- Debouncer, per button:
  - The counter increments each cycle the synchronized level differs from the debounced level.
  - The counter clears on any cycle where the two are equal.
  - When the count reaches DB_CYCLES, the debounced level takes the new value and the counter clears.
  - Pulses shorter than DB_CYCLES cycles are ignored.
- FSM states: IDLE, UP_HELD, DN_HELD, LOCK.
  - IDLE, debounced up rises alone → UP_HELD; `m`<=0, `step` pulses.
  - IDLE, debounced dn rises alone → DN_HELD; `m`<=1, `step` pulses.
  - IDLE, both rise in the same cycle → LOCK; no `step`, `m` unchanged.
  - UP_HELD/DN_HELD, other button's debounced level rises → LOCK; no `step`.
  - UP_HELD/DN_HELD, own button's debounced level falls → IDLE; no `step`.
  - UP_HELD/DN_HELD, auto-repeat (REP_DELAY≠0): the hold counter starts at the press `step`.
    - `step` pulses after REP_DELAY cycles, then every REP_PERIOD cycles while held.
    - `m` stays at the held direction.
  - LOCK → IDLE only when both debounced levels are 0. Releasing just one button stays in LOCK; no steps are issued from LOCK.
- `m` changes only in the same cycle as a `step` pulse and otherwise holds its last value. `m` is valid whenever `step`=1.
- `step` is never high for two consecutive cycles when REP_PERIOD≥2. With REP_PERIOD=1, `step` is continuous during repeat.
- `lock`=1 exactly while the state is LOCK.

## Timing
- Press latency: `step` is high in the cycle after the (DB_CYCLES+3)th rising edge, counting from the first edge that samples the raw button high. The bounce-free 3 cycles are 2 for the synchronizer and 1 for the FSM register.
- Release latency: the debounced level falls DB_CYCLES+2 edges after the raw release. A new press is accepted only after that.
- Repeat: the first repeat `step` is exactly REP_DELAY cycles after the press `step`. Later ones are spaced REP_PERIOD cycles apart.
- Reset asserted mid-hold: outputs clear within the same cycle, asynchronously.
  - After `clr` deasserts with a button still held, a fresh press is detected with full press latency.
- A reset deasserted while a button bounces produces at most one `step`.

## Test plan
- Reset: `clr`=0 with both buttons high → `m`=0, `step`=0, `lock`=0 immediately. Release `clr`, keep btn_up=1 → one `step` at edge 19 (DB_CYCLES=16), `m`=0.
- Bounce reject: btn_dn toggling with high pulses of 5 cycles for 200 cycles, then steady 1 → exactly one `step`, with `m`=1, 19 cycles after the steady edge.
- Auto-repeat: hold btn_up for 150 cycles after the press `step` (REP_DELAY=64, REP_PERIOD=16) → repeat steps at +64, +80, +96, +112, +128, +144; 7 steps total; `m`=0 throughout.
- Conflict: hold btn_up, then press btn_dn → `lock`=1, no further steps. Release btn_up only → `lock` stays 1. Release btn_dn → `lock`=0 after debounce, state IDLE, no `step`.
- Direction change: up press then release, then down press → the second `step` has `m`=1. `m` stays 1 after release, until the next up press.
- REP_DELAY=0: hold btn_dn for 500 cycles → exactly one `step`.
